// File: rtl/ram_bist.sv
// March C- style BIST controller driving a single-port synchronous RAM.
// Reports pass/fail plus the address and data of the first mismatch.
module ram_bist #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             WE,
    output logic             RE,
    output logic [ADDR-1:0]  addr,
    output logic [WIDTH-1:0] WD,
    input  logic [WIDTH-1:0] RD,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [ADDR-1:0]  fail_addr,
    output logic [WIDTH-1:0] fail_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR-1:0]  A_ZERO = {ADDR{1'b0}};
    localparam logic [ADDR-1:0]  A_LAST = ADDR'(DEPTH - 1);
    localparam logic [WIDTH-1:0] P0     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] P1     = {WIDTH{1'b1}};
    localparam logic [2:0]       E_LAST = 3'd5;

    state_t          state;
    logic [2:0]      elem;
    logic [ADDR-1:0] acnt;

    logic            at_end_s;
    logic [2:0]      next_elem_s;
    logic [ADDR-1:0] next_first_s;
    logic [ADDR-1:0] step_addr_s;

    // Elements M3..M5 walk the address space downwards.
    function automatic logic descending(input logic [2:0] e);
        return (e >= 3'd3);
    endfunction

    function automatic logic [ADDR-1:0] first_addr(input logic [2:0] e);
        return descending(e) ? A_LAST : A_ZERO;
    endfunction

    function automatic logic [ADDR-1:0] end_addr(input logic [2:0] e);
        return descending(e) ? A_ZERO : A_LAST;
    endfunction

    function automatic logic [WIDTH-1:0] read_pat(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? P1 : P0;
    endfunction

    function automatic logic [WIDTH-1:0] write_pat(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? P1 : P0;
    endfunction

    // Address-sequencing helpers for the current march element.
    always_comb begin
        at_end_s     = (acnt == end_addr(elem));
        next_elem_s  = elem + 3'd1;
        next_first_s = first_addr(next_elem_s);
        if (descending(elem)) begin
            step_addr_s = acnt - ADDR'(1);
        end else begin
            step_addr_s = acnt + ADDR'(1);
        end
    end

    // March sequencer with registered RAM strobes and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= 3'd0;
            acnt      <= A_ZERO;
            WE        <= 1'b0;
            RE        <= 1'b0;
            addr      <= A_ZERO;
            WD        <= P0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= A_ZERO;
            fail_data <= P0;
        end else begin
            WE   <= 1'b0;
            RE   <= 1'b0;
            addr <= A_ZERO;
            WD   <= P0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WRITE;
                        elem      <= 3'd0;
                        acnt      <= A_ZERO;
                        WE        <= 1'b1;
                        addr      <= A_ZERO;
                        WD        <= P0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= A_ZERO;
                        fail_data <= P0;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (at_end_s) begin
                        // Every element after M0 begins with a read.
                        state <= READ;
                        elem  <= next_elem_s;
                        acnt  <= next_first_s;
                        RE    <= 1'b1;
                        addr  <= next_first_s;
                    end else if (elem == 3'd0) begin
                        state <= WRITE;
                        acnt  <= step_addr_s;
                        WE    <= 1'b1;
                        addr  <= step_addr_s;
                        WD    <= P0;
                    end else begin
                        state <= READ;
                        acnt  <= step_addr_s;
                        RE    <= 1'b1;
                        addr  <= step_addr_s;
                    end
                end
                READ: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (RD != read_pat(elem)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_addr <= acnt;
                        fail_data <= RD;
                    end else if (elem == E_LAST) begin
                        if (at_end_s) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end else begin
                            state <= READ;
                            acnt  <= step_addr_s;
                            RE    <= 1'b1;
                            addr  <= step_addr_s;
                        end
                    end else begin
                        state <= WRITE;
                        WE    <= 1'b1;
                        addr  <= acnt;
                        WD    <= write_pat(elem);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: fault-free runs, two stuck-at faults,
// ignored start pulse and mid-test reset, against a behavioural RAM.
module tb_ram_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       WE, RE, busy, done, pass, fail;
    logic [3:0] addr, WD, fail_addr, fail_data;
    logic [3:0] RD = 4'd0;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] mem [16];
    logic       fault_on = 1'b0;
    logic [3:0] fault_addr = 4'd0;
    logic [3:0] set_mask = 4'd0;
    logic [3:0] clr_mask = 4'd0;

    int         cyc, nwe, nre, viol, last_acc;
    logic       seen, we1;
    logic [3:0] a1;

    ram_bist #(.WIDTH(4), .DEPTH(16), .ADDR(4)) dut (
        .clk(clk), .rst(rst), .start(start), .WE(WE), .RE(RE), .addr(addr),
        .WD(WD), .RD(RD), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] faulty(input logic [3:0] d, input logic [3:0] a);
        if (fault_on && (a == fault_addr)) return (d | set_mask) & ~clr_mask;
        return d;
    endfunction

    always @(posedge clk) begin
        if (WE) mem[addr] <= WD;
        if (RE) RD <= faulty(mem[addr], addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {10'd0, WE, RE, addr, WD, busy, done, pass, fail, fail_addr, fail_data};
    endfunction

    // Starts a test from IDLE and steps until done, a reset point or the cycle bound.
    task automatic run(input int pulse_at, input int rst_at);
        cyc = 0; nwe = 0; nre = 0; viol = 0; last_acc = 0; seen = 1'b0;
        we1 = 1'b0; a1 = 4'hx;
        start = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
            if (cyc == 1) begin
                we1 = WE;
                a1  = addr;
            end
            if (WE) nwe++;
            if (RE) nre++;
            if (WE || RE) last_acc = cyc;
            if ((WE && RE) || (!WE && !RE && (addr != 4'd0 || WD != 4'd0))) viol++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;

        // Reset for two cycles, then idle with start low.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", all_outs(), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", all_outs(), 32'd0);
        end

        // Reset wins over start.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_over_start", all_outs(), 32'd0);
        @(negedge clk);
        chk("rst_over_start_idle", all_outs(), 32'd0);

        // Fault-free run.
        run(0, 0);
        chk("ff_first_we", {31'd0, we1}, 32'd1);
        chk("ff_first_addr", {28'd0, a1}, 32'd0);
        chk("ff_done_seen", {31'd0, seen}, 32'd1);
        chk("ff_done_cycle", cyc, 32'd241);
        chk("ff_status", {28'd0, busy, pass, fail, done}, {28'd0, 4'b0101});
        chk("ff_we_count", nwe, 32'd80);
        chk("ff_re_count", nre, 32'd80);
        chk("ff_strobe_rules", viol, 32'd0);
        @(negedge clk);
        chk("ff_done_pulse_end", {30'd0, done, pass}, {30'd0, 2'b01});

        // Bit0 stuck at 1 at address 5: caught in M1.
        fault_on = 1'b1; fault_addr = 4'd5; set_mask = 4'b0001; clr_mask = 4'b0000;
        run(0, 0);
        chk("sa1_done_cycle", cyc, 32'd34);
        chk("sa1_status", {28'd0, busy, pass, fail, done}, {28'd0, 4'b0011});
        chk("sa1_fail_addr", {28'd0, fail_addr}, 32'd5);
        chk("sa1_fail_data", {28'd0, fail_data}, 32'd1);
        chk("sa1_last_access", last_acc, 32'd32);
        @(negedge clk);
        chk("sa1_hold", {22'd0, done, fail, fail_addr, fail_data}, {22'd0, 2'b01, 4'd5, 4'd1});

        // Bit3 stuck at 0 at address 15: caught in M2.
        fault_addr = 4'd15; set_mask = 4'b0000; clr_mask = 4'b1000;
        run(0, 0);
        chk("sa0_done_cycle", cyc, 32'd112);
        chk("sa0_fail_addr", {28'd0, fail_addr}, 32'd15);
        chk("sa0_fail_data", {28'd0, fail_data}, 32'd7);
        chk("sa0_flags", {30'd0, pass, fail}, {30'd0, 2'b01});
        @(negedge clk);
        fault_on = 1'b0;

        // Start pulse mid-test is ignored.
        run(20, 0);
        chk("ign_done_cycle", cyc, 32'd241);
        chk("ign_pass", {30'd0, pass, fail}, {30'd0, 2'b10});
        @(negedge clk);

        // Reset at cycle 50 of a test.
        run(0, 50);
        chk("mid_reset_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_outputs", all_outs(), 32'd0);

        // Full run after the reset.
        run(0, 0);
        chk("post_rst_done_cycle", cyc, 32'd241);
        chk("post_rst_pass", {30'd0, pass, fail}, {30'd0, 2'b10});
        chk("post_rst_we_count", nwe, 32'd80);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 Parameter: WIDTH, 4, RAM data width in bits.
REQ-002 Parameter: DEPTH, 16, number of RAM words tested; addresses 0..DEPTH-1.
REQ-003 Parameter: ADDR, 4, RAM address width; DEPTH <= 2^ADDR.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  test request; sampled only in IDLE.
REQ-007 Port: WE  output  1  RAM write enable.
REQ-008 Port: RE  output  1  RAM read enable.
REQ-009 Port: addr  output  ADDR  RAM address.
REQ-010 Port: WD  output  WIDTH  RAM write data.
REQ-011 Port: RD  input  WIDTH  RAM read data; valid in the cycle after a RE=1 cycle.
REQ-012 Port: busy  output  1  high while a test is running.
REQ-013 Port: done  output  1  one-cycle pulse at test end.
REQ-014 Port: pass  output  1  level; last test completed without mismatch.
REQ-015 Port: fail  output  1  level; last test aborted on a mismatch.
REQ-016 Port: fail_addr  output  ADDR  address of the first mismatch.
REQ-017 Port: fail_data  output  WIDTH  RD value observed at the first mismatch.

Function
REQ-018 The block SHALL be the sole initiator of the attached single-port synchronous RAM. The RAM writes WD at addr on the edge where WE=1, and registers RD one cycle after RE=1.
REQ-019 States SHALL be IDLE, WRITE, READ, CHECK and DONE. A march-element counter (0..5) and an address counter SHALL qualify the states.
REQ-020 March sequence, P0 = all zeros, P1 = all ones:
- M0: ascending, w P0
- M1: ascending, r P0, w P1
- M2: ascending, r P1, w P0
- M3: descending, r P0, w P1
- M4: descending, r P1, w P0
- M5: descending, r P0
REQ-021 Each operation SHALL take one cycle.
- Read: READ cycle (RE=1, WE=0), then CHECK cycle (RE=0, WE=0, RD compared with the expected pattern).
- Write: WRITE cycle (WE=1, RE=0, WD=pattern).
- Per address in M1-M4, the order SHALL be READ, CHECK, WRITE.
REQ-022 WE and RE SHALL never both be 1. Outside READ and WRITE, both SHALL be 0 and addr/WD SHALL be 0.
REQ-023 IDLE with start=1 at edge E0 SHALL set busy=1 and clear pass/fail/fail_addr/fail_data. The first WRITE (M0, addr 0) SHALL occur in cycle E0+1.
REQ-024 A full test SHALL occupy 15*DEPTH RAM cycles. For DEPTH=16 that is 240 cycles: 80 writes, 80 reads, 80 checks.
REQ-025 Address wrap rules:
- Ascending elements SHALL advance 0 to DEPTH-1.
- Descending elements SHALL advance DEPTH-1 to 0.
- At the last address, the next element SHALL start with no idle cycle.
REQ-026 In the cycle after the final M5 CHECK, the block SHALL enter DONE: done=1, busy=0, pass=1. The next cycle SHALL return to IDLE with done=0.
REQ-027 On the first CHECK mismatch, the block SHALL abort with no further RAM access:
- capture fail_addr and fail_data;
- set fail=1;
- enter DONE in the next cycle, where done=1 and busy=0.
REQ-028 pass, fail, fail_addr and fail_data SHALL hold until the next accepted start or reset.
REQ-029 start SHALL be ignored in WRITE, READ, CHECK and DONE. A start held high through DONE SHALL be accepted in the following IDLE cycle.

Reset
REQ-030 rst=1 at any edge, including mid-test, SHALL force IDLE. From the next cycle, every output SHALL be 0: WE, RE, addr, WD, busy, done, pass, fail, fail_addr, fail_data.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 Assert rst for 2 cycles -> all outputs 0. start=0 for 10 cycles afterwards -> outputs remain 0, no WE/RE.
REQ-033 Fault-free RAM, one-cycle start -> first WE at addr 0 in the next cycle; done=1 exactly 241 cycles after the start edge; pass=1, fail=0; 80 WE and 80 RE cycles counted.
REQ-034 RAM model with bit0 stuck at 1 at addr 5 -> mismatch in M1 CHECK at addr 5; fail=1, fail_addr=5, fail_data=4'b0001, pass=0; done next cycle; no RAM access after that CHECK.
REQ-035 RAM model with bit3 stuck at 0 at addr 15 -> M2 CHECK at addr 15; fail_addr=15, fail_data=4'b0111.
REQ-036 Pulse start again at cycle 20 of a test -> ignored; done still at cycle 241. Then rst at cycle 50 of a new test -> all outputs 0 next cycle. A subsequent start -> full 240-cycle run with pass=1.
